// File: rtl/data_memory_responder.sv
// data_memory_responder: MEM-stage byte-addressed, big-endian data memory.
// Ports: Clk/Reset (async, active-low); request bundle MemEnable,
//   MemReadWrite, MemSize, MemSignE, Address, DataIn; results DataOut,
//   MemReady (1-cycle pulse), AlignError, and combinational MemStall.
module data_memory_responder #(
    parameter int    ADDR_WIDTH  = 9,
    parameter int    DEPTH       = 512,
    parameter int    WAIT_STATES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  MemEnable,
    input  logic                  MemReadWrite,
    input  logic [1:0]            MemSize,
    input  logic                  MemSignE,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [31:0]           DataIn,
    output logic [31:0]           DataOut,
    output logic                  MemReady,
    output logic                  MemStall,
    output logic                  AlignError
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U = DEPTH;
    localparam logic [3:0] CNT_LOAD =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic                  rw;
        logic [1:0]            size;
        logic                  sign_e;
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           data;
    } req_t;

    state_t state, next_state;
    logic [3:0] count;
    req_t req_q, req;
    logic fire, misalign, out_of_range, bad;
    logic [2:0] nbytes;
    logic [31:0] last_byte, rdata;
    logic [IW-1:0] i0, i1, i2, i3;
    logic [7:0] mem [DEPTH];

    // With zero wait states the access happens on the request edge itself,
    // so the live inputs stand in for the not-yet-captured request.
    always_comb begin
        req = req_q;
        if (state == IDLE) begin
            req = {MemReadWrite, MemSize, MemSignE, Address, DataIn};
        end
    end

    always_comb begin
        next_state = state;
        fire = 1'b0;
        unique case (state)
            IDLE: begin
                if (MemEnable) begin
                    if (WAIT_STATES == 0) begin
                        next_state = DONE;
                        fire = 1'b1;
                    end else begin
                        next_state = BUSY;
                    end
                end
            end
            BUSY: begin
                if (count == 4'd0) begin
                    next_state = DONE;
                    fire = 1'b1;
                end
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        case (req.size)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    end

    assign misalign = (req.size == 2'b01 && req.addr[0])
                    || (req.size[1] && req.addr[1:0] != 2'b00);
    assign last_byte = 32'(req.addr) + 32'(nbytes) - 32'd1;
    assign out_of_range = (last_byte >= DEPTH_U);
    assign bad = misalign | out_of_range;

    assign i0 = IW'(req.addr);
    assign i1 = IW'(32'(req.addr) + 32'd1);
    assign i2 = IW'(32'(req.addr) + 32'd2);
    assign i3 = IW'(32'(req.addr) + 32'd3);

    always_comb begin
        case (req.size)
            2'b00: rdata = {{24{req.sign_e & mem[i0][7]}}, mem[i0]};
            2'b01: rdata = {{16{req.sign_e & mem[i0][7]}}, mem[i0], mem[i1]};
            default: rdata = {mem[i0], mem[i1], mem[i2], mem[i3]};
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count      <= 4'd0;
            req_q      <= '0;
            DataOut    <= 32'h0;
            MemReady   <= 1'b0;
            AlignError <= 1'b0;
        end else begin
            MemReady   <= fire;
            AlignError <= fire & bad;
            if (state == IDLE && MemEnable) begin
                req_q <= req;
                count <= CNT_LOAD;
            end else if (state == BUSY && count != 4'd0) begin
                count <= count - 4'd1;
            end
            // Good writes keep the last read result; faults force zero.
            if (fire && (bad || !req.rw)) begin
                DataOut <= bad ? 32'h0 : rdata;
            end
        end
    end

    // Storage is deliberately not reset; an aborted access never gets here.
    always_ff @(posedge Clk) begin
        if (fire && req.rw && !bad) begin
            case (req.size)
                2'b00: mem[i0] <= req.data[7:0];
                2'b01: begin
                    mem[i0] <= req.data[15:8];
                    mem[i1] <= req.data[7:0];
                end
                default: begin
                    mem[i0] <= req.data[31:24];
                    mem[i1] <= req.data[23:16];
                    mem[i2] <= req.data[15:8];
                    mem[i3] <= req.data[7:0];
                end
            endcase
        end
    end

    assign MemStall = MemEnable & ~MemReady;

endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed bench with a result scoreboard.
// Drives a WAIT_STATES=2 instance and a WAIT_STATES=0, 256-byte instance.
module tb_data_memory_responder;

    logic        clk;
    logic        reset;
    logic        en2, en0;
    logic        rw;
    logic [1:0]  size;
    logic        sign_e;
    logic [8:0]  addr;
    logic [31:0] din;
    logic [31:0] dout2, dout0;
    logic        rdy2, rdy0, stall2, stall0, aerr2, aerr0;

    int checks = 0;
    int failures = 0;
    logic [31:0] held2 = 32'h0;
    logic [31:0] held0 = 32'h0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    data_memory_responder #(
        .ADDR_WIDTH(9), .DEPTH(512), .WAIT_STATES(2), .INIT_FILE("")
    ) dut (
        .Clk(clk), .Reset(reset), .MemEnable(en2), .MemReadWrite(rw),
        .MemSize(size), .MemSignE(sign_e), .Address(addr), .DataIn(din),
        .DataOut(dout2), .MemReady(rdy2), .MemStall(stall2),
        .AlignError(aerr2)
    );

    data_memory_responder #(
        .ADDR_WIDTH(9), .DEPTH(256), .WAIT_STATES(0), .INIT_FILE("")
    ) dut0 (
        .Clk(clk), .Reset(reset), .MemEnable(en0), .MemReadWrite(rw),
        .MemSize(size), .MemSignE(sign_e), .Address(addr), .DataIn(din),
        .DataOut(dout0), .MemReady(rdy0), .MemStall(stall0),
        .AlignError(aerr0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy_of(input bit sel);
        return sel ? rdy0 : rdy2;
    endfunction

    function automatic logic stall_of(input bit sel);
        return sel ? stall0 : stall2;
    endfunction

    // One complete access; rd is the expected read value (reads only).
    task automatic run(input string tag, input bit sel, input logic w,
                       input logic [1:0] sz, input logic se,
                       input logic [8:0] a, input logic [31:0] d,
                       input logic [31:0] rd, input logic er);
        exp_t e;
        logic [31:0] ed;
        int lat;
        int stalls;
        int ws;
        ws = sel ? 0 : 2;
        ed = er ? 32'h0 : (w ? (sel ? held0 : held2) : rd);
        if (sel) held0 = ed;
        else held2 = ed;
        exp_q.push_back('{data: ed, err: er, lat: ws + 1});
        @(negedge clk);
        rw = w; size = sz; sign_e = se; addr = a; din = d;
        if (sel) en0 = 1'b1;
        else en2 = 1'b1;
        #1;
        stalls = stall_of(sel) ? 1 : 0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (!rdy_of(sel)) begin
                if (stall_of(sel)) stalls++;
                addr = 9'($urandom);
                din = $urandom;
                size = 2'($urandom);
                rw = ~w;
                sign_e = ~se;
            end
        end while (!rdy_of(sel) && lat < 20);
        e = exp_q.pop_front();
        check({tag, "/latency"}, 32'(lat), 32'(e.lat));
        check({tag, "/stall_cycles"}, 32'(stalls), 32'(ws + 1));
        check({tag, "/stall_in_done"}, 32'(stall_of(sel)), 32'd0);
        check({tag, "/data"}, sel ? dout0 : dout2, e.data);
        check({tag, "/align"}, 32'(sel ? aerr0 : aerr2), 32'(e.err));
        en0 = 1'b0;
        en2 = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "/ready_drop"}, 32'(rdy_of(sel)), 32'd0);
    endtask

    initial begin
        exp_t e;
        int lat;
        reset = 1'b1;
        en2 = 1'b0; en0 = 1'b0;
        rw = 1'b0; size = 2'b00; sign_e = 1'b0;
        addr = '0; din = '0;
        #1 reset = 1'b0;
        #2;
        check("rst/dout", dout2, 32'h0);
        check("rst/ready", 32'(rdy2), 32'd0);
        check("rst/align", 32'(aerr2), 32'd0);
        check("rst/stall", 32'(stall2), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run("w_deadbeef", 0, 1, 2'b10, 0, 9'd8, 32'hDEADBEEF, 0, 0);
        run("r_w8", 0, 0, 2'b10, 0, 9'd8, 0, 32'hDEADBEEF, 0);
        run("r_sb8", 0, 0, 2'b00, 1, 9'd8, 0, 32'hFFFFFFDE, 0);
        run("r_ub9", 0, 0, 2'b00, 0, 9'd9, 0, 32'h000000AD, 0);
        run("r_sh10", 0, 0, 2'b01, 1, 9'd10, 0, 32'hFFFFBEEF, 0);
        run("r_uh8", 0, 0, 2'b01, 0, 9'd8, 0, 32'h0000DEAD, 0);
        run("w_b11", 0, 1, 2'b00, 0, 9'd11, 32'h12345655, 0, 0);
        run("r_w8b", 0, 0, 2'b10, 0, 9'd8, 0, 32'hDEADBE55, 0);
        run("w_h8", 0, 1, 2'b01, 0, 9'd8, 32'hFFFF1234, 0, 0);
        run("r_w8h", 0, 0, 2'b10, 1, 9'd8, 0, 32'h1234BE55, 0);
        run("r_sz11", 0, 0, 2'b11, 1, 9'd8, 0, 32'h1234BE55, 0);
        run("w_w4", 0, 1, 2'b10, 0, 9'd4, 32'h01020304, 0, 0);
        run("w_mis6", 0, 1, 2'b10, 0, 9'd6, 32'hAAAAAAAA, 0, 1);
        run("r_w4", 0, 0, 2'b10, 0, 9'd4, 0, 32'h01020304, 0);
        run("r_w8m", 0, 0, 2'b10, 0, 9'd8, 0, 32'h1234BE55, 0);
        run("r_h9", 0, 0, 2'b01, 0, 9'd9, 0, 0, 1);
        run("r_sb4", 0, 0, 2'b00, 1, 9'd4, 0, 32'h00000001, 0);

        run("z_w16", 1, 1, 2'b10, 0, 9'd16, 32'hCAFEBABE, 0, 0);
        run("z_r16", 1, 0, 2'b10, 0, 9'd16, 0, 32'hCAFEBABE, 0);
        run("z_ub17", 1, 0, 2'b00, 0, 9'd17, 0, 32'h000000FE, 0);
        run("z_wb255", 1, 1, 2'b00, 0, 9'd255, 32'h00000080, 0, 0);
        run("z_sb255", 1, 0, 2'b00, 1, 9'd255, 0, 32'hFFFFFF80, 0);
        run("z_rng_r", 1, 0, 2'b10, 0, 9'd256, 0, 0, 1);
        run("z_rng_w", 1, 1, 2'b00, 0, 9'd256, 32'h11, 0, 1);
        run("z_r16b", 1, 0, 2'b10, 0, 9'd16, 0, 32'hCAFEBABE, 0);

        // back-to-back: MemEnable stays high through DONE
        exp_q.push_back('{data: 32'h1234BE55, err: 1'b0, lat: 3});
        exp_q.push_back('{data: 32'h01020304, err: 1'b0, lat: 3});
        @(negedge clk);
        rw = 1'b0; size = 2'b10; sign_e = 1'b0; addr = 9'd8;
        en2 = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!rdy2 && lat < 20);
        e = exp_q.pop_front();
        check("b2b1/latency", 32'(lat), 32'(e.lat));
        check("b2b1/data", dout2, e.data);
        check("b2b1/stall_in_done", 32'(stall2), 32'd0);
        addr = 9'd4;
        @(posedge clk);
        #1;
        check("b2b/idle_ready", 32'(rdy2), 32'd0);
        check("b2b/idle_stall", 32'(stall2), 32'd1);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!rdy2 && lat < 20);
        e = exp_q.pop_front();
        check("b2b2/latency", 32'(lat), 32'(e.lat));
        check("b2b2/data", dout2, e.data);
        check("b2b2/align", 32'(aerr2), 32'(e.err));
        en2 = 1'b0;
        held2 = 32'h01020304;
        @(posedge clk);

        // reset while a write to address 0 is in BUSY
        run("w_w0", 0, 1, 2'b10, 0, 9'd0, 32'h11223344, 0, 0);
        @(negedge clk);
        rw = 1'b1; size = 2'b10; sign_e = 1'b0; addr = 9'd0;
        din = 32'hCAFEF00D;
        en2 = 1'b1;
        @(posedge clk);
        #1;
        check("abort/busy_stall", 32'(stall2), 32'd1);
        #2;
        reset = 1'b0;
        en2 = 1'b0;
        #1;
        check("abort/dout", dout2, 32'h0);
        check("abort/ready", 32'(rdy2), 32'd0);
        check("abort/align", 32'(aerr2), 32'd0);
        check("abort/stall", 32'(stall2), 32'd0);
        check("abort/dout0", dout0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        held2 = 32'h0;
        held0 = 32'h0;
        #1;
        check("post/stall_low", 32'(stall2), 32'd0);
        en2 = 1'b1;
        #1;
        check("post/stall_high", 32'(stall2), 32'd1);
        en2 = 1'b0;
        #1;
        check("post/stall_drop", 32'(stall2), 32'd0);
        run("r_w0", 0, 0, 2'b10, 0, 9'd0, 0, 32'h11223344, 0);
        run("r_w4p", 0, 0, 2'b10, 0, 9'd4, 0, 32'h01020304, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
